// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver.
//   Recovers DBIT-bit frames (LSB first) from the asynchronous rx line using
//   the s_tick strobe from the baud generator; each bit is sampled at its
//   midpoint (8 ticks into the start bit, then every 16 ticks).
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit; otherwise parity_err is tied 0.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   synchronous active-low reset
//   s_tick       in   oversampling strobe, 16 per bit period
//   rx           in   asynchronous serial line, idle high
//   dout         out  last received data word
//   rx_done_tick out  one-clk pulse when a frame completes
//   frame_err    out  stop bit sampled low in the last frame
//   parity_err   out  parity mismatch in the last frame
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      sync_q;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  // par_q holds the mismatch computed in PARITY until the frame completes.
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      sync_q  <= '1;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      sync_q  <= {sync_q[0], rx};
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // Falling edge is detected without waiting for a tick.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            b_d = {rx_s, b_q[DBIT-1:1]};
            s_d = '0;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            par_d   = (^b_q) ^ rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            dout_d  = b_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (DBIT=8, SB_TICK=16).
//   s_tick is high one clk in four, so a serial bit lasts 64 clk. Expected
//   frames are queued before each transmission; a monitor pops and compares
//   on every rx_done_tick. Build with UART_RX_PARITY_EN to add parity cases.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  int   p0;

`ifdef UART_RX_PARITY_EN
  localparam int EXP_PULSES = 9;
`else
  localparam int EXP_PULSES = 7;
`endif

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
    exp_q.push_back('{d: d, fe: fe, pe: pe});
  endtask

  // stop_low > 0 drives the first stop_low clk of the stop bit low.
  task automatic send(input logic [7:0] d, input int stop_low, input logic pflip);
    hold(1'b0, 64);
    for (int i = 0; i < 8; i++) hold(d[i], 64);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ pflip, 64);
`endif
    if (stop_low > 0) begin
      hold(1'b0, stop_low);
      hold(1'b1, 64 - stop_low);
    end else begin
      hold(1'b1, 64);
    end
  endtask

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rx_done_tick === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got dout=%0h expected no pulse", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("frame_err", 32'(frame_err), 32'(e.fe));
          check("parity_err", 32'(parity_err), 32'(e.pe));
        end
      end
    end
  end

  initial begin
    logic [7:0] mid;
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_perr", 32'(parity_err), 32'h0);
    reset_n = 1'b1;
    hold(1'b1, 64);

    // Basic frame
    expect_frame(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 0, 1'b0);
    hold(1'b1, 64);

    // Short low glitch is rejected
    p0 = pulses;
    hold(1'b0, 12);
    hold(1'b1, 64 * 3);
    check("glitch_no_pulse", 32'(pulses), 32'(p0));
    check("glitch_dout_held", 32'(dout), 32'hA5);

    // Framing error, then clean frame
    expect_frame(8'h3C, 1'b1, 1'b0);
    send(8'h3C, 48, 1'b0);
    hold(1'b1, 64);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 0, 1'b0);
    hold(1'b1, 64);

    // Back-to-back frames
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    expect_frame(8'h55, 1'b0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hFF, 0, 1'b0);
    send(8'h55, 0, 1'b0);
    hold(1'b1, 64);

    // Reset in the middle of data bit 4 of 0x81; the sender abandons the frame
    p0  = pulses;
    mid = 8'h81;
    hold(1'b0, 64);
    for (int i = 0; i < 4; i++) hold(mid[i], 64);
    hold(mid[4], 32);
    reset_n = 1'b0;
    rx      = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 64 * 12);
    check("midreset_no_pulse", 32'(pulses), 32'(p0));
    check("midreset_dout", 32'(dout), 32'h0);
    check("midreset_ferr", 32'(frame_err), 32'h0);
    expect_frame(8'h7E, 1'b0, 1'b0);
    send(8'h7E, 0, 1'b0);
    hold(1'b1, 64);

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h0F, 1'b0, 1'b0);
    send(8'h0F, 0, 1'b0);
    hold(1'b1, 64);
    expect_frame(8'h0F, 1'b0, 1'b1);
    send(8'h0F, 0, 1'b1);
    hold(1'b1, 64);
`endif

    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("pulse_count", 32'(pulses), 32'(EXP_PULSES));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
